// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver: assembles WIDTH-bit words from a bit stream
// (direction latched per word) into a one-entry valid/ready holding register.
module shift_deserializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             r_l,
  input  logic             clear,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned   CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  logic             dir_eff;
  logic [WIDTH-1:0] shifted;
  logic             accept, complete, drain, load;

  always_comb begin
    // The first bit of a word uses r_l directly; later bits use the latched copy.
    dir_eff  = (cnt_q == '0) ? r_l : dir_q;
    shifted  = dir_eff ? {sr_q[WIDTH-2:0], sin} : {sin, sr_q[WIDTH-1:1]};
    accept   = sin_valid & ~clear;
    complete = accept & (cnt_q == CNT_LAST);
    drain    = valid_q & out_ready;
    load     = complete & (~valid_q | drain);

    sr_d      = sr_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = complete & valid_q & ~out_ready;

    if (clear) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (sin_valid) begin
      sr_d  = shifted;
      dir_d = dir_eff;
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end

    if (load) begin
      data_d  = shifted;
      valid_d = 1'b1;
    end else if (drain) begin
      valid_d = 1'b0;
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench for shift_deserializer: directed words are pushed as expected
// results; a forked monitor pops and compares on every output handshake.
module tb_shift_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sin, sin_valid, r_l, clear, out_ready;
  logic [7:0] out_data;
  logic       out_valid, busy, overrun;

  int         checks = 0;
  int         errors = 0;
  int         ovr_cnt = 0;
  logic [7:0] exp_q[$];

  shift_deserializer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sin      (sin),
    .sin_valid(sin_valid),
    .r_l      (r_l),
    .clear    (clear),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b, input logic rl);
    sin       = b;
    r_l       = rl;
    sin_valid = 1'b1;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] msb_bits;
    rst_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; r_l = 1'b0; clear = 1'b0; out_ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && overrun) ovr_cnt++;
        if (rst_n && out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
          else chk("word", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        end
      end
    join_none

    // Reset held with random serial activity
    for (int i = 0; i < 4; i++) begin
      sin = 1'($urandom); sin_valid = 1'($urandom); r_l = 1'($urandom); out_ready = 1'($urandom);
      @(negedge clk);
      chk("rst_valid", {31'd0, out_valid}, 0);
      chk("rst_data", {24'd0, out_data}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_overrun", {31'd0, overrun}, 0);
    end
    sin_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // LSB-first 0xA5
    out_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_bit(1'b1, 1'b0);
    chk("lsb_busy", {31'd0, busy}, 1);
    for (int i = 1; i < 8; i++) begin
      logic [7:0] a5 = 8'hA5;
      send_bit(a5[i], 1'b0);
    end
    chk("lsb_valid", {31'd0, out_valid}, 1);
    chk("lsb_data", {24'd0, out_data}, 32'hA5);
    chk("lsb_busy_done", {31'd0, busy}, 0);
    idle(1);
    chk("lsb_valid_one_cycle", {31'd0, out_valid}, 0);

    // MSB-first 0x3C, r_l flipped to 0 after bit 3
    exp_q.push_back(8'h3C);
    msb_bits = 8'b0011_1100;
    for (int i = 7; i >= 0; i--) send_bit(msb_bits[i], (i >= 5) ? 1'b1 : 1'b0);
    chk("msb_data", {24'd0, out_data}, 32'h3C);
    idle(1);

    // Back-pressure: 0x11 held, 0x22 dropped
    out_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_word(8'h11);
    chk("bp_valid", {31'd0, out_valid}, 1);
    chk("bp_overrun_none", {31'd0, overrun}, 0);
    send_word(8'h22);
    chk("bp_overrun_pulse", {31'd0, overrun}, 1);
    chk("bp_data_held", {24'd0, out_data}, 32'h11);
    idle(1);
    chk("bp_overrun_one_cycle", {31'd0, overrun}, 0);
    out_ready = 1'b1;
    idle(1);
    chk("bp_drained", {31'd0, out_valid}, 0);
    out_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_word(8'h11);
    chk("bp_reload", {24'd0, out_data}, 32'h11);

    // Simultaneous drain (0x11) and load (0x5A)
    exp_q.push_back(8'h5A);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w = 8'h5A;
      if (i == 7) out_ready = 1'b1;
      send_bit(w[i], 1'b0);
    end
    out_ready = 1'b0;
    chk("sim_data", {24'd0, out_data}, 32'h5A);
    chk("sim_valid", {31'd0, out_valid}, 1);
    chk("sim_overrun", {31'd0, overrun}, 0);
    out_ready = 1'b1;
    idle(1);

    // Clear mid-word with a simultaneous bit
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    chk("clr_busy_before", {31'd0, busy}, 1);
    clear = 1'b1;
    send_bit(1'b1, 1'b0);
    clear = 1'b0;
    chk("clr_busy_after", {31'd0, busy}, 0);
    exp_q.push_back(8'h96);
    send_word(8'h96);
    chk("clr_word", {24'd0, out_data}, 32'h96);
    idle(1);

    // Async reset with pending word and partial word
    out_ready = 1'b0;
    send_word(8'h77);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
    chk("ar_pending", {31'd0, out_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 0);
    chk("ar_data", {24'd0, out_data}, 0);
    chk("ar_busy", {31'd0, busy}, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_word(8'hC3);
    chk("ar_word", {24'd0, out_data}, 32'hC3);
    idle(2);

    chk("overrun_total", ovr_cnt, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
